// File: rtl/screen_ram_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | screen_ram_arbiter_pkg                                           |
// | FSM state encodings and screen geometry for the screen RAM.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package screen_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VGA_RD = 2'd1,
    ST_CPU_RD = 2'd2,
    ST_CPU_WR = 2'd3
  } arb_state_t;

  localparam int SCREEN_WIDTH    = 640;
  localparam int SCREEN_HEIGHT   = 480;
  localparam int WINDOW_WIDTH    = 488;
  localparam int WINDOW_HEIGHT   = 280;
  localparam int PIXEL_BITS      = 4;
  localparam int PIXELS_PER_WORD = 8;
  localparam logic [24:0] START_ADDR = 25'd0;

endpackage : screen_ram_arbiter_pkg
`default_nettype wire

// File: rtl/screen_ram_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | screen_ram_arbiter_if                                            |
// | Requester ports (VGA scanout, CPU) plus the single-port RAM bus. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface screen_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 32
) ();

  logic                  vga_req;
  logic [ADDR_WIDTH-1:0] vga_addr;
  logic [DATA_WIDTH-1:0] vga_data;
  logic                  vga_valid;

  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [3:0]            cpu_be;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_ack;

  logic                  ram_en;
  logic [3:0]            ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  vga_req, vga_addr,
    output vga_data, vga_valid,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_rdata, cpu_ack,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  // Requesters plus the RAM itself
  modport master (
    output vga_req, vga_addr,
    input  vga_data, vga_valid,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_rdata, cpu_ack,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface : screen_ram_arbiter_if
`default_nettype wire

// File: rtl/screen_ram_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | screen_ram_arbiter                                               |
// | VGA-priority arbiter with CPU anti-starvation for a screen RAM.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module screen_ram_arbiter #(
  parameter int ADDR_WIDTH   = 25,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  screen_ram_arbiter_if.slave bus
);

  import screen_ram_arbiter_pkg::*;

  localparam int              CNT_W        = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  logic [CNT_W-1:0]      r_starve_cnt;

  logic                  r_ram_en;
  logic [3:0]            r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wdata;
  logic [DATA_WIDTH-1:0] r_vga_data;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;

  logic w_arb;
  logic w_cpu_priority;
  logic w_grant_vga;
  logic w_grant_cpu;
  logic w_vga_done;
  logic w_cpu_done;
  logic w_cpu_rd_done;

  // Every access is a command cycle (ram_en high) then a completion cycle;
  // arbitration runs in IDLE and in every completion cycle.
  assign w_arb          = (r_state == ST_IDLE) || !r_ram_en;
  assign w_cpu_priority = bus.cpu_req && (r_starve_cnt == C_STARVE_MAX);
  assign w_grant_vga    = w_arb && bus.vga_req && !w_cpu_priority;
  assign w_grant_cpu    = w_arb && bus.cpu_req && !w_grant_vga;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_arb) begin
      if (w_grant_vga) begin
        w_next_state = ST_VGA_RD;
      end else if (w_grant_cpu) begin
        w_next_state = bus.cpu_we ? ST_CPU_WR : ST_CPU_RD;
      end else begin
        w_next_state = ST_IDLE;
      end
    end
  end

  always_comb begin
    w_vga_done    = 1'b0;
    w_cpu_done    = 1'b0;
    w_cpu_rd_done = 1'b0;
    case (r_state)
      ST_VGA_RD: w_vga_done = !r_ram_en;
      ST_CPU_RD: begin
        w_cpu_done    = !r_ram_en;
        w_cpu_rd_done = !r_ram_en;
      end
      ST_CPU_WR: w_cpu_done = !r_ram_en;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!bus.cpu_req || w_grant_cpu) begin
      r_starve_cnt <= '0;
    end else if (w_grant_vga && (r_starve_cnt != C_STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 4'b0000;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else if (w_arb) begin
      r_ram_en <= w_grant_vga || w_grant_cpu;
      r_ram_we <= (w_grant_cpu && bus.cpu_we) ? bus.cpu_be : 4'b0000;
      if (w_grant_vga) begin
        r_ram_addr <= bus.vga_addr;
      end else if (w_grant_cpu) begin
        r_ram_addr <= bus.cpu_addr;
      end
      if (w_grant_cpu && bus.cpu_we) begin
        r_ram_wdata <= bus.cpu_wdata;
      end
    end else begin
      r_ram_en <= 1'b0;
      r_ram_we <= 4'b0000;
    end
  end

  // Read data arrives in the completion cycle; the pulse cycle forwards it
  // directly and the holding register keeps it until the next pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vga_data  <= '0;
      r_cpu_rdata <= '0;
    end else begin
      if (w_vga_done) begin
        r_vga_data <= bus.ram_rdata;
      end
      if (w_cpu_rd_done) begin
        r_cpu_rdata <= bus.ram_rdata;
      end
    end
  end

  assign bus.ram_en    = r_ram_en;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.vga_valid = w_vga_done;
  assign bus.cpu_ack   = w_cpu_done;
  assign bus.vga_data  = w_vga_done ? bus.ram_rdata : r_vga_data;
  assign bus.cpu_rdata = w_cpu_rd_done ? bus.ram_rdata : r_cpu_rdata;

endmodule : screen_ram_arbiter
`default_nettype wire

// File: tb/tb_screen_ram_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_screen_ram_arbiter                                            |
// | Directed bench with a byte-enabled synchronous RAM model.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_screen_ram_arbiter;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  logic [31:0] mem [0:255];

  screen_ram_arbiter_if #(.ADDR_WIDTH(25), .DATA_WIDTH(32)) bus ();

  screen_ram_arbiter #(
    .ADDR_WIDTH  (25),
    .DATA_WIDTH  (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM preloads while the bench holds reset; read data lands one cycle after ram_en
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h20] <= 32'hAABBCCDD;
      mem[8'h30] <= 32'h0BADF00D;
      bus.ram_rdata <= 32'h0;
    end else if (bus.ram_en) begin
      if (bus.ram_we == 4'b0000) begin
        bus.ram_rdata <= mem[bus.ram_addr[7:0]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_we[b]) mem[bus.ram_addr[7:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic cpu_set(input logic req, input logic we, input logic [24:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_be    = be;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.vga_req  = 1'b0;
    bus.vga_addr = '0;
    cpu_set(1'b0, 1'b0, 25'h0, 32'h0, 4'h0);
    tick();
    tick();

    chk("rst_ram_en",    {31'b0, bus.ram_en},    32'h0);
    chk("rst_ram_we",    {28'b0, bus.ram_we},    32'h0);
    chk("rst_ram_addr",  {7'b0, bus.ram_addr},   32'h0);
    chk("rst_ram_wdata", bus.ram_wdata,          32'h0);
    chk("rst_vga_valid", {31'b0, bus.vga_valid}, 32'h0);
    chk("rst_cpu_ack",   {31'b0, bus.cpu_ack},   32'h0);
    chk("rst_vga_data",  bus.vga_data,           32'h0);
    chk("rst_cpu_rdata", bus.cpu_rdata,          32'h0);

    // Single VGA fetch: command at cycle 1, data at cycle 2
    rst_n        = 1'b1;
    bus.vga_req  = 1'b1;
    bus.vga_addr = 25'h10;
    tick();
    chk("vga_cmd_en",    {31'b0, bus.ram_en},    32'h1);
    chk("vga_cmd_addr",  {7'b0, bus.ram_addr},   32'h10);
    chk("vga_cmd_we",    {28'b0, bus.ram_we},    32'h0);
    chk("vga_cmd_valid", {31'b0, bus.vga_valid}, 32'h0);
    tick();
    chk("vga_valid",     {31'b0, bus.vga_valid}, 32'h1);
    chk("vga_data",      bus.vga_data,           32'hDEADBEEF);
    chk("vga_done_en",   {31'b0, bus.ram_en},    32'h0);
    bus.vga_req = 1'b0;
    tick();
    chk("vga_valid_drop", {31'b0, bus.vga_valid}, 32'h0);
    chk("vga_data_hold",  bus.vga_data,           32'hDEADBEEF);
    chk("idle_en",        {31'b0, bus.ram_en},    32'h0);

    // Partial write to 0x20 then read back
    cpu_set(1'b1, 1'b1, 25'h20, 32'h12345678, 4'b0011);
    tick();
    chk("wr_en",    {31'b0, bus.ram_en},  32'h1);
    chk("wr_we",    {28'b0, bus.ram_we},  32'h3);
    chk("wr_addr",  {7'b0, bus.ram_addr}, 32'h20);
    chk("wr_wdata", bus.ram_wdata,        32'h12345678);
    chk("wr_ack0",  {31'b0, bus.cpu_ack}, 32'h0);
    tick();
    chk("wr_ack",   {31'b0, bus.cpu_ack}, 32'h1);
    chk("wr_we_off", {28'b0, bus.ram_we}, 32'h0);
    cpu_set(1'b0, 1'b0, 25'h20, 32'h0, 4'h0);
    tick();
    chk("wr_ack_drop", {31'b0, bus.cpu_ack}, 32'h0);
    cpu_set(1'b1, 1'b0, 25'h20, 32'h0, 4'h0);
    tick();
    chk("rd_en", {31'b0, bus.ram_en}, 32'h1);
    chk("rd_we", {28'b0, bus.ram_we}, 32'h0);
    tick();
    chk("rd_ack",   {31'b0, bus.cpu_ack}, 32'h1);
    chk("rd_rdata", bus.cpu_rdata,        32'hAABB5678);
    cpu_set(1'b0, 1'b0, 25'h0, 32'h0, 4'h0);
    tick();

    // Write with no byte enables: acked, RAM untouched, cpu_rdata held
    cpu_set(1'b1, 1'b1, 25'h20, 32'hFFFFFFFF, 4'b0000);
    tick();
    chk("be0_we", {28'b0, bus.ram_we}, 32'h0);
    tick();
    chk("be0_ack",        {31'b0, bus.cpu_ack}, 32'h1);
    chk("be0_rdata_hold", bus.cpu_rdata,        32'hAABB5678);
    cpu_set(1'b1, 1'b0, 25'h20, 32'h0, 4'h0);
    tick();
    tick();
    chk("be0_readback", bus.cpu_rdata, 32'hAABB5678);
    cpu_set(1'b0, 1'b0, 25'h0, 32'h0, 4'h0);
    tick();

    // Simultaneous first requests: VGA then CPU
    bus.vga_req  = 1'b1;
    bus.vga_addr = 25'h10;
    cpu_set(1'b1, 1'b0, 25'h30, 32'h0, 4'h0);
    tick();
    chk("sim_first_addr", {7'b0, bus.ram_addr}, 32'h10);
    tick();
    chk("sim_vga_valid", {31'b0, bus.vga_valid}, 32'h1);
    chk("sim_cpu_wait",  {31'b0, bus.cpu_ack},   32'h0);
    bus.vga_req = 1'b0;
    tick();
    chk("sim_second_addr", {7'b0, bus.ram_addr}, 32'h30);
    chk("sim_second_en",   {31'b0, bus.ram_en},  32'h1);
    tick();
    chk("sim_cpu_ack",   {31'b0, bus.cpu_ack}, 32'h1);
    chk("sim_cpu_rdata", bus.cpu_rdata,        32'h0BADF00D);
    cpu_set(1'b0, 1'b0, 25'h0, 32'h0, 4'h0);
    tick();

    // Both held: completions every 2 cycles in the order V,V,V,V,C
    bus.vga_req = 1'b1;
    cpu_set(1'b1, 1'b0, 25'h30, 32'h0, 4'h0);
    for (int t = 1; t <= 20; t++) begin
      logic exp_v;
      logic exp_c;
      tick();
      exp_v = (t % 2 == 0) && ((t / 2) % 5 != 0);
      exp_c = (t % 2 == 0) && ((t / 2) % 5 == 0);
      chk($sformatf("pat_vga_valid_t%0d", t), {31'b0, bus.vga_valid}, {31'b0, exp_v});
      chk($sformatf("pat_cpu_ack_t%0d", t),   {31'b0, bus.cpu_ack},   {31'b0, exp_c});
    end
    bus.vga_req = 1'b0;
    cpu_set(1'b0, 1'b0, 25'h0, 32'h0, 4'h0);
    tick();
    chk("pat_idle_en", {31'b0, bus.ram_en}, 32'h0);

    // Reset during a CPU read aborts it
    cpu_set(1'b1, 1'b0, 25'h30, 32'h0, 4'h0);
    tick();
    chk("abort_cmd_en", {31'b0, bus.ram_en}, 32'h1);
    rst_n = 1'b0;
    tick();
    chk("abort_ack",       {31'b0, bus.cpu_ack},   32'h0);
    chk("abort_ram_en",    {31'b0, bus.ram_en},    32'h0);
    chk("abort_ram_addr",  {7'b0, bus.ram_addr},   32'h0);
    chk("abort_cpu_rdata", bus.cpu_rdata,          32'h0);
    chk("abort_vga_data",  bus.vga_data,           32'h0);
    chk("abort_vga_valid", {31'b0, bus.vga_valid}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_en",   {31'b0, bus.ram_en},  32'h1);
    chk("post_rst_ack0", {31'b0, bus.cpu_ack}, 32'h0);
    tick();
    chk("post_rst_ack",   {31'b0, bus.cpu_ack}, 32'h1);
    chk("post_rst_rdata", bus.cpu_rdata,        32'h0BADF00D);
    cpu_set(1'b0, 1'b0, 25'h0, 32'h0, 4'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_screen_ram_arbiter
`default_nettype wire

// File: doc/screen_ram_arbiter.md
SCREEN_RAM_ARBITER -- requirements
Module: screen_ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 25: word address width of screen RAM.
REQ-002 Parameter DATA_WIDTH, default 32: word width; eight 4-bit pixels per word.
REQ-003 Parameter STARVE_LIMIT, default 4: consecutive VGA grants allowed while CPU waits.
REQ-004 clk  in  1  sole clock.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 vga_req  in  1  scanout fetch request, level, held until vga_valid.
REQ-007 vga_addr  in  ADDR_WIDTH  scanout word address.
REQ-008 vga_data  out  DATA_WIDTH  fetched word.
REQ-009 vga_valid  out  1  one-cycle pulse: vga_data valid.
REQ-010 cpu_req  in  1  CPU access request, level, held with stable fields until cpu_ack.
REQ-011 cpu_we  in  1  1 = write, 0 = read.
REQ-012 cpu_addr  in  ADDR_WIDTH  CPU word address.
REQ-013 cpu_wdata  in  DATA_WIDTH  write data.
REQ-014 cpu_be  in  4  byte enables for writes.
REQ-015 cpu_rdata  out  DATA_WIDTH  read data, valid with cpu_ack on reads.
REQ-016 cpu_ack  out  1  one-cycle completion pulse.
REQ-017 ram_en, ram_we[3:0], ram_addr[ADDR_WIDTH-1:0], ram_wdata[DATA_WIDTH-1:0]  out  single-port RAM command.
REQ-018 ram_rdata  in  DATA_WIDTH  RAM read data, valid exactly one cycle after ram_en with ram_we==0.

Function
REQ-019 FSM states: IDLE, VGA_RD, CPU_RD, CPU_WR; exactly one RAM command per access.
REQ-020 IDLE: issue registered RAM command for winner, move to its state; no request -> stay IDLE, ram_en=0.
REQ-021 Arbitration: VGA wins unless cpu_req pending and starve_cnt==STARVE_LIMIT; then CPU wins.
REQ-022 starve_cnt: +1 per VGA grant while cpu_req high; cleared on CPU grant or when cpu_req low; saturates at STARVE_LIMIT.
REQ-023 VGA_RD: one cycle after command, latch ram_rdata to vga_data, pulse vga_valid, return IDLE; total latency vga_req to vga_valid = 2 cycles from IDLE.
REQ-024 CPU_RD: same timing; cpu_rdata latched, cpu_ack pulsed.
REQ-025 CPU_WR: ram_we=cpu_be for the command cycle; cpu_ack pulses next cycle; cpu_be==0 still acks, RAM unchanged.
REQ-026 Back-to-back: from VGA_RD/CPU_RD/CPU_WR completion cycle, arbitration for next command occurs in same cycle (no IDLE bubble), giving one access per 2 cycles sustained.
REQ-027 Simultaneous vga_req and cpu_req with starve_cnt<STARVE_LIMIT: VGA first.
REQ-028 Request dropped before completion: access completes, pulse still issued; requester ignores.
REQ-029 ram_addr, ram_wdata, ram_we registered; ram_we=0 whenever ram_en=0.
REQ-030 vga_data and cpu_rdata hold last value between pulses.

Reset
REQ-031 On rst_n==0 at clk edge: state=IDLE, starve_cnt=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, vga_valid=0, cpu_ack=0, vga_data=0, cpu_rdata=0.
REQ-032 Reset mid-access aborts it; no vga_valid or cpu_ack pulse for the aborted access; first command earliest one cycle after rst_n returns high.

Structure
REQ-033 Shared package holds state encodings (IDLE=0, VGA_RD=1, CPU_RD=2, CPU_WR=3) and screen constants (640x480, 488x280 window, START_ADDR=0).
REQ-034 Single flat module; no sub-module; RAM instantiated outside.

Verification
REQ-035 Reset then vga_req, vga_addr=0x10, RAM word 0xDEADBEEF -> ram_en at cycle 1, vga_valid with vga_data=0xDEADBEEF at cycle 2.
REQ-036 cpu_req write addr=0x20, wdata=0x12345678, be=4'b0011 -> ram_we=0011 one cycle, cpu_ack next; read-back returns low half 0x5678 updated.
REQ-037 vga_req and cpu_req held high continuously -> grant order V,V,V,V,C repeating; CPU ack every 10 cycles.
REQ-038 Simultaneous first requests, starve_cnt=0 -> VGA served first, CPU served next slot.
REQ-039 rst_n low during CPU_RD -> no cpu_ack, all outputs at reset values next cycle.
REQ-040 cpu_we=1, cpu_be=0 -> cpu_ack pulses, RAM contents unchanged.
